gate_vector_checker: RTL and testbench

Synthesizable self-checking stimulus engine for the lab's single-output combinational gate blocks. On `start` it drives every input combination to a device under test and holds each one for a programmable settle time. At the end of each hold it samples the DUT output and compares it against a golden function selected by `op_sel`. It then reports the error count, the first failing vector and pass/fail. It sits beside a gate instance on the FPGA top, taking the place of a simulation-only stimulus bench.

---
 rtl/gate_vector_checker_pkg.sv | 18 +
 rtl/gate_vector_checker_if.sv | 27 ++
 rtl/gate_vector_checker_golden.sv | 25 ++
 rtl/gate_vector_checker.sv | 126 ++++++++++++
 tb/tb_gate_vector_checker.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_vector_checker_pkg.sv
// Shared types for the gate vector checker: golden operation select and
// checker FSM state encodings.
package gate_check_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } chk_state_e;

endpackage

// File: rtl/gate_vector_checker_if.sv
// Control, stimulus and result bundle between the gate vector checker (slave)
// and whatever sits beside it on the board top (master).
interface gate_vector_checker_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic              start;
  logic [1:0]        op_sel;
  logic              dut_y;
  logic [N_IN-1:0]   dut_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [N_IN-1:0]   first_fail_vec;
  logic              first_fail_valid;

  modport master (
    output start, op_sel, dut_y,
    input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, op_sel, dut_y,
    output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_vector_checker_golden.sv
// Combinational golden reference: the expected output of an N_IN-input
// gate for the selected operation.
module gate_golden
  import gate_check_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  gate_op_e        op,
  input  logic [N_IN-1:0] vec,
  output logic            exp_y
);

  // Reduction selected by the latched operation
  always_comb begin
    exp_y = 1'b0;
    case (op)
      OP_AND:  exp_y = &vec;
      OP_OR:   exp_y = |vec;
      OP_XOR:  exp_y = ^vec;
      OP_NAND: exp_y = ~(&vec);
      default: exp_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus engine: walks every input vector, holds each for
// HOLD_CYCLES, compares the DUT output with the golden gate and reports.
module gate_vector_checker
  import gate_check_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  gate_vector_checker_if.slave bus
);

  localparam int                HC_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0]   VEC_LAST  = {N_IN{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  chk_state_e        state_r;
  gate_op_e          op_r;
  logic [HC_W-1:0]   hold_cnt_r;
  logic [N_IN-1:0]   vec_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic [ERR_W-1:0]  err_count_r;
  logic [N_IN-1:0]   ff_vec_r;
  logic              ff_valid_r;

  logic              exp_y_s;
  logic              sample_s;
  logic              mismatch_s;
  logic [ERR_W-1:0]  err_next_s;

  gate_golden #(.N_IN(N_IN)) u_golden (
    .op    (op_r),
    .vec   (vec_r),
    .exp_y (exp_y_s)
  );

  // Sample strobe at the end of each hold window and the saturated error count
  always_comb begin
    sample_s   = (state_r == ST_APPLY) && (hold_cnt_r == HOLD_LAST);
    mismatch_s = sample_s && (bus.dut_y != exp_y_s);
    if (mismatch_s && (err_count_r != ERR_MAX)) begin
      err_next_s = err_count_r + ERR_W'(1);
    end else begin
      err_next_s = err_count_r;
    end
  end

  // Checker FSM with all result outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_AND;
      hold_cnt_r  <= '0;
      vec_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= '0;
      ff_vec_r    <= '0;
      ff_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r     <= ST_APPLY;
            busy_r      <= 1'b1;
            vec_r       <= '0;
            hold_cnt_r  <= '0;
            op_r        <= gate_op_e'(bus.op_sel);
            err_count_r <= '0;
            pass_r      <= 1'b0;
            ff_vec_r    <= '0;
            ff_valid_r  <= 1'b0;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_APPLY: begin
          err_count_r <= err_next_s;
          if (mismatch_s && !ff_valid_r) begin
            ff_vec_r   <= vec_r;
            ff_valid_r <= 1'b1;
          end
          // The last vector is terminal: no wrap back to zero
          if (sample_s) begin
            if (vec_r == VEC_LAST) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (err_next_s == '0);
            end else begin
              vec_r      <= vec_r + N_IN'(1);
              hold_cnt_r <= '0;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + HC_W'(1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_in           = vec_r;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.pass             = pass_r;
  assign bus.err_count        = err_count_r;
  assign bus.first_fail_vec   = ff_vec_r;
  assign bus.first_fail_valid = ff_valid_r;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three parameterisations checked every cycle
// against a timeline model of the run, plus literal result expectations.
module tb_gate_vector_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic       start_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [1:0] op_v    [3] = '{2'd0, 2'd0, 2'd0};
  int         kind_v  [3] = '{0, 0, 0};

  function automatic int n_of(int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic int h_of(int i);
    return (i == 2) ? 1 : 10;
  endfunction
  function automatic int e_of(int i);
    return (i == 1) ? 1 : 8;
  endfunction
  function automatic int total(int i);
    return (1 << n_of(i)) * h_of(i);
  endfunction

  // Gate function by population count: 0 AND, 1 OR, 2 XOR, 3 NAND
  function automatic logic gfun(int op, int v, int n);
    int ones;
    ones = 0;
    for (int b = 0; b < n; b++) ones += (v >> b) & 1;
    case (op)
      0:       return ones == n;
      1:       return ones > 0;
      2:       return (ones % 2) == 1;
      default: return ones != n;
    endcase
  endfunction

  gate_vector_checker_if #(.N_IN(2), .ERR_W(8)) if_a ();
  gate_vector_checker_if #(.N_IN(2), .ERR_W(1)) if_b ();
  gate_vector_checker_if #(.N_IN(3), .ERR_W(8)) if_c ();

  assign if_a.start  = start_v[0];
  assign if_a.op_sel = op_v[0];
  assign if_a.dut_y  = gfun(kind_v[0], int'(if_a.dut_in), 2);
  assign if_b.start  = start_v[1];
  assign if_b.op_sel = op_v[1];
  assign if_b.dut_y  = gfun(kind_v[1], int'(if_b.dut_in), 2);
  assign if_c.start  = start_v[2];
  assign if_c.op_sel = op_v[2];
  assign if_c.dut_y  = gfun(kind_v[2], int'(if_c.dut_in), 3);

  gate_vector_checker #(.N_IN(2), .HOLD_CYCLES(10), .ERR_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  gate_vector_checker #(.N_IN(2), .HOLD_CYCLES(10), .ERR_W(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  gate_vector_checker #(.N_IN(3), .HOLD_CYCLES(1),  .ERR_W(8)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  // Model state: edges elapsed since the accepted start, capped one past DONE
  bit started_m [3];
  int t_m       [3];
  int op_m      [3];
  int kind_m    [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        started_m[i] <= 1'b0;
        t_m[i]       <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if ((!started_m[i] || t_m[i] > total(i)) && start_v[i]) begin
          started_m[i] <= 1'b1;
          t_m[i]       <= 0;
          op_m[i]      <= int'(op_v[i]);
          kind_m[i]    <= kind_v[i];
        end else if (started_m[i] && t_m[i] <= total(i)) begin
          t_m[i] <= t_m[i] + 1;
        end
      end
    end
  end

  task automatic cmp(string nm, int i, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d, expected %0d (cycle %0d)", nm, i, act, want, cyc);
    end
  endtask

  task automatic snap(int i, output logic b, output logic d, output logic p, output logic fo,
                      output int e, output int fv, output int di);
    case (i)
      0: begin
        b = if_a.busy; d = if_a.done; p = if_a.pass; fo = if_a.first_fail_valid;
        e = int'(if_a.err_count); fv = int'(if_a.first_fail_vec); di = int'(if_a.dut_in);
      end
      1: begin
        b = if_b.busy; d = if_b.done; p = if_b.pass; fo = if_b.first_fail_valid;
        e = int'(if_b.err_count); fv = int'(if_b.first_fail_vec); di = int'(if_b.dut_in);
      end
      default: begin
        b = if_c.busy; d = if_c.done; p = if_c.pass; fo = if_c.first_fail_valid;
        e = int'(if_c.err_count); fv = int'(if_c.first_fail_vec); di = int'(if_c.dut_in);
      end
    endcase
  endtask

  task automatic check_inst(int i);
    logic b, d, p, fo;
    int e, fv, di;
    int n, h, tot, t, cnt, e_w, fv_w, di_w;
    logic fo_w, b_w, d_w, p_w;
    snap(i, b, d, p, fo, e, fv, di);
    n = n_of(i); h = h_of(i); tot = total(i); t = t_m[i];
    e_w = 0; fv_w = 0; fo_w = 1'b0; b_w = 1'b0; d_w = 1'b0; p_w = 1'b0; di_w = 0;
    if (started_m[i]) begin
      cnt = t / h;
      if (cnt > (1 << n)) cnt = 1 << n;
      for (int k = 0; k < cnt; k++) begin
        if (gfun(op_m[i], k, n) != gfun(kind_m[i], k, n)) begin
          e_w++;
          if (!fo_w) begin
            fo_w = 1'b1;
            fv_w = k;
          end
        end
      end
      if (e_w > (1 << e_of(i)) - 1) e_w = (1 << e_of(i)) - 1;
      b_w  = t < tot;
      d_w  = t == tot;
      p_w  = (t >= tot) && (e_w == 0);
      di_w = (t < tot) ? t / h : (1 << n) - 1;
    end
    cmp("busy", i, int'(b), int'(b_w));
    cmp("done", i, int'(d), int'(d_w));
    cmp("pass", i, int'(p), int'(p_w));
    cmp("err_count", i, e, e_w);
    cmp("first_fail_valid", i, int'(fo), int'(fo_w));
    cmp("first_fail_vec", i, fv, fv_w);
    cmp("dut_in", i, di, di_w);
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) check_inst(i);
    end
  end

  task automatic go(int i, int op, int kind);
    @(negedge clk);
    op_v[i]    = 2'(op);
    kind_v[i]  = kind;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int budget, output int lat);
    logic b, d, p, fo;
    int e, fv, di;
    lat = 0;
    d = 1'b0;
    while (!d && lat < budget) begin
      @(negedge clk);
      lat++;
      snap(i, b, d, p, fo, e, fv, di);
      if ($urandom_range(0, 3) == 0) op_v[i] = 2'($urandom_range(0, 3));
    end
    if (!d) cmp("done_timeout", i, 0, 1);
  endtask

  task automatic results(int i, int e_w, int p_w, int fo_w, int fv_w);
    logic b, d, p, fo;
    int e, fv, di;
    snap(i, b, d, p, fo, e, fv, di);
    cmp("lit_err_count", i, e, e_w);
    cmp("lit_pass", i, int'(p), p_w);
    cmp("lit_ff_valid", i, int'(fo), fo_w);
    cmp("lit_ff_vec", i, fv, fv_w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic b, d, p, fo;
    int e, fv, di, lat, b1, b2;
    logic prev;

    repeat (3) @(negedge clk);
    snap(0, b, d, p, fo, e, fv, di);
    cmp("rst_busy", 0, int'(b), 0);
    cmp("rst_done", 0, int'(d), 0);
    cmp("rst_err", 0, e, 0);
    cmp("rst_dut_in", 0, di, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // AND DUT, AND golden
    go(0, 0, 0);
    wait_done(0, 60, lat);
    cmp("done_latency", 0, lat, 40);
    results(0, 0, 1, 0, 0);

    // AND DUT, OR golden
    go(0, 1, 0);
    wait_done(0, 60, lat);
    results(0, 2, 0, 1, 1);

    // AND DUT, XOR golden, 1-bit counter saturates
    go(1, 2, 0);
    wait_done(1, 60, lat);
    results(1, 1, 0, 1, 1);

    // NAND golden, 3 inputs, hold 1: matching then AND DUT
    go(2, 3, 3);
    wait_done(2, 20, lat);
    cmp("done_latency", 2, lat, 8);
    results(2, 0, 1, 0, 0);
    go(2, 3, 0);
    wait_done(2, 20, lat);
    results(2, 8, 0, 1, 0);

    // start held high across a whole run
    @(negedge clk);
    op_v[0] = 2'd1; kind_v[0] = 0; start_v[0] = 1'b1;
    b1 = -1; b2 = -1; prev = 1'b0;
    for (int c = 0; c < 120 && b2 < 0; c++) begin
      @(negedge clk);
      snap(0, b, d, p, fo, e, fv, di);
      if (b && !prev) begin
        if (b1 < 0) b1 = cyc;
        else b2 = cyc;
      end
      prev = b;
    end
    cmp("restart_gap", 0, b2 - b1, 42);
    start_v[0] = 1'b0;
    wait_done(0, 60, lat);

    // Asynchronous reset in the middle of a run that has already failed a vector
    go(0, 3, 0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    snap(0, b, d, p, fo, e, fv, di);
    cmp("arst_busy", 0, int'(b), 0);
    cmp("arst_err", 0, e, 0);
    cmp("arst_ff_valid", 0, int'(fo), 0);
    cmp("arst_dut_in", 0, di, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go(0, 0, 0);
    wait_done(0, 60, lat);
    cmp("done_latency_after_rst", 0, lat, 40);
    results(0, 0, 1, 0, 0);

    // Randomised runs with mid-run op_sel noise
    repeat (24) begin
      int i, op, kd;
      i  = $urandom_range(0, 2);
      op = $urandom_range(0, 3);
      kd = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      go(i, op, kd);
      wait_done(i, total(i) + 20, lat);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
